// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_issue_ctrl
// Brief    : Issues MDU commands from the E stage, tracks the MDU busy window,
//            stalls HI/LO-dependent D-stage instructions, flags protocol errors.
// Revision : 1.0  initial release
// ============================================================================
module mdu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  D_MDUOP,
    input  logic [1:0]  D_ReadHILO,
    input  logic        E_Valid,
    input  logic [3:0]  E_MDUOP,
    input  logic [1:0]  E_ReadHILO,
    input  logic        Flush,
    input  logic        Busy,
    output logic        Start,
    output logic [3:0]  MDUOP,
    output logic [3:0]  Time,
    output logic [1:0]  ReadHILO,
    output logic        Stall,
    output logic        ProtoErr,
    output logic [15:0] StallCnt
);

    localparam logic [3:0] MUL_TIME = 4'd5;
    localparam logic [3:0] DIV_TIME = 4'd10;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_GCD   = 4'b1000;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        proto_err_q, proto_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        live;
    logic        launch_op;
    logic        d_uses;
    logic        violation;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            proto_err_q <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        live      = E_Valid & ~Flush;
        launch_op = (E_MDUOP == OP_MULT) | (E_MDUOP == OP_MULTU) |
                    (E_MDUOP == OP_DIV)  | (E_MDUOP == OP_DIVU)  |
                    (E_MDUOP == OP_GCD);
        d_uses    = (D_MDUOP != 4'd0) | (D_ReadHILO != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    cnt_d   = Time;
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Leave RUN in the same cycle the count reaches zero.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase

        violation = (~Busy & (cnt_q != 4'd0)) |
                    (Busy & (state_q == ST_IDLE) & ~Start) |
                    (live & launch_op & (state_q == ST_RUN));
        proto_err_d = proto_err_q | violation;

        stall_cnt_d = stall_cnt_q;
        if (Stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        case (E_MDUOP)
            OP_MULT, OP_MULTU:       Time = MUL_TIME;
            OP_DIV, OP_DIVU, OP_GCD: Time = DIV_TIME;
            default:                 Time = 4'd0;
        endcase
        Start    = live & launch_op & (state_q == ST_IDLE);
        MDUOP    = live ? E_MDUOP : 4'd0;
        ReadHILO = live ? E_ReadHILO : 2'b00;
        Stall    = d_uses & (Start | (cnt_q != 4'd0) | Busy);
        ProtoErr = proto_err_q;
        StallCnt = stall_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_issue_ctrl
// Brief    : Directed bench for mdu_issue_ctrl with a small MDU busy model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  D_MDUOP;
    logic [1:0]  D_ReadHILO;
    logic        E_Valid;
    logic [3:0]  E_MDUOP;
    logic [1:0]  E_ReadHILO;
    logic        Flush;
    logic        Busy;
    logic        Start;
    logic [3:0]  MDUOP;
    logic [3:0]  Time;
    logic [1:0]  ReadHILO;
    logic        Stall;
    logic        ProtoErr;
    logic [15:0] StallCnt;

    logic [3:0]  mdu_cnt;
    logic        drop_en;
    logic        busy_force;
    logic        hi_written;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl u_dut (
        .clk        (clk),
        .reset      (reset),
        .D_MDUOP    (D_MDUOP),
        .D_ReadHILO (D_ReadHILO),
        .E_Valid    (E_Valid),
        .E_MDUOP    (E_MDUOP),
        .E_ReadHILO (E_ReadHILO),
        .Flush      (Flush),
        .Busy       (Busy),
        .Start      (Start),
        .MDUOP      (MDUOP),
        .Time       (Time),
        .ReadHILO   (ReadHILO),
        .Stall      (Stall),
        .ProtoErr   (ProtoErr),
        .StallCnt   (StallCnt)
    );

    // MDU model: busy from the Start cycle through Time further cycles.
    assign Busy = busy_force |
                  ((Start | (mdu_cnt != 4'd0)) & ~(drop_en & (mdu_cnt == 4'd3)));

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_cnt    <= 4'd0;
            hi_written <= 1'b0;
        end else begin
            if (Start)                mdu_cnt <= Time;
            else if (mdu_cnt != 4'd0) mdu_cnt <= mdu_cnt - 4'd1;
            if (MDUOP == 4'b0101)     hi_written <= 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ev, input logic [3:0] eop, input logic [1:0] erd,
                       input logic fl, input logic [3:0] dop, input logic [1:0] drd);
        @(negedge clk);
        E_Valid    = ev;
        E_MDUOP    = eop;
        E_ReadHILO = erd;
        Flush      = fl;
        D_MDUOP    = dop;
        D_ReadHILO = drd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        D_MDUOP    = 4'd0;
        D_ReadHILO = 2'b00;
        E_Valid    = 1'b0;
        E_MDUOP    = 4'd0;
        E_ReadHILO = 2'b00;
        Flush      = 1'b0;
        drop_en    = 1'b0;
        busy_force = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_proto", ProtoErr, 0);
        check_val("rst_stallcnt", StallCnt, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("idle_start", Start, 0);
        check_val("idle_stall", Stall, 0);
        check_val("idle_proto", ProtoErr, 0);
        check_val("idle_stallcnt", StallCnt, 0);
        check_val("idle_mduop", MDUOP, 0);

        // mult in E, mflo in D
        cyc(1'b1, 4'b0001, 2'b00, 1'b0, 4'd0, 2'b01);
        check_val("mult_start", Start, 1);
        check_val("mult_time", Time, 5);
        check_val("mult_mduop", MDUOP, 1);
        check_val("mult_stall0", Stall, 1);
        for (int j = 1; j <= 5; j++) begin
            cyc(1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01);
            check_val("mult_stall", Stall, 1);
            check_val("mult_nostart", Start, 0);
        end
        cyc(1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01);
        check_val("mult_release", Stall, 0);
        check_val("mult_stallcnt", StallCnt, 6);
        cyc(1'b1, 4'd0, 2'b01, 1'b0, 4'd0, 2'b00);
        check_val("mflo_readhilo", ReadHILO, 1);
        check_val("mflo_start", Start, 0);
        check_val("mult_proto", ProtoErr, 0);

        // div then dependent divu
        cyc(1'b1, 4'b0011, 2'b00, 1'b0, 4'b0100, 2'b00);
        check_val("div_start", Start, 1);
        check_val("div_time", Time, 10);
        check_val("div_stall0", Stall, 1);
        for (int j = 1; j <= 10; j++) begin
            cyc(1'b0, 4'd0, 2'b00, 1'b0, 4'b0100, 2'b00);
            check_val("div_stall", Stall, 1);
            check_val("div_nostart", Start, 0);
        end
        cyc(1'b1, 4'b0100, 2'b00, 1'b0, 4'd0, 2'b00);
        check_val("divu_start_k11", Start, 1);
        check_val("divu_time", Time, 10);
        check_val("divu_mduop", MDUOP, 4);
        check_val("div_stallcnt", StallCnt, 17);
        idle(11);
        check_val("divchain_proto", ProtoErr, 0);
        check_val("divchain_stallcnt", StallCnt, 17);

        // flushed divu and mthi
        cyc(1'b1, 4'b0100, 2'b00, 1'b1, 4'd0, 2'b00);
        check_val("flush_start", Start, 0);
        check_val("flush_mduop", MDUOP, 0);
        cyc(1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01);
        check_val("flush_idle_stall", Stall, 0);
        check_val("flush_proto", ProtoErr, 0);
        cyc(1'b1, 4'b0101, 2'b00, 1'b1, 4'd0, 2'b00);
        check_val("flush_mthi_mduop", MDUOP, 0);
        idle(1);
        check_val("flush_mthi_hi", hi_written, 0);
        cyc(1'b1, 4'b0101, 2'b00, 1'b0, 4'b0110, 2'b00);
        check_val("mthi_mduop", MDUOP, 5);
        check_val("mthi_stall", Stall, 0);
        check_val("mthi_start", Start, 0);
        idle(1);
        check_val("mthi_hi", hi_written, 1);

        // MDU drops Busy at cnt=3
        drop_en = 1'b1;
        cyc(1'b1, 4'b0001, 2'b00, 1'b0, 4'd0, 2'b00);
        check_val("drop_start", Start, 1);
        idle(3);
        check_val("drop_proto_pre", ProtoErr, 0);
        idle(1);
        check_val("drop_proto", ProtoErr, 1);
        idle(3);
        check_val("drop_proto_held", ProtoErr, 1);
        drop_en = 1'b0;
        do_reset();
        check_val("clr_proto", ProtoErr, 0);

        // Busy high while idle
        @(negedge clk);
        busy_force = 1'b1;
        #1;
        check_val("force_proto_pre", ProtoErr, 0);
        @(negedge clk);
        busy_force = 1'b0;
        #1;
        check_val("force_proto", ProtoErr, 1);
        do_reset();

        // launch-class op in E during RUN
        cyc(1'b1, 4'b0010, 2'b00, 1'b0, 4'd0, 2'b00);
        check_val("multu_start", Start, 1);
        check_val("multu_time", Time, 5);
        cyc(1'b1, 4'b0001, 2'b00, 1'b0, 4'd0, 2'b00);
        check_val("run_nostart", Start, 0);
        check_val("run_proto_pre", ProtoErr, 0);
        idle(1);
        check_val("run_proto", ProtoErr, 1);
        idle(5);
        do_reset();

        // reset while a div is running at cnt=4
        cyc(1'b1, 4'b0011, 2'b00, 1'b0, 4'd0, 2'b01);
        check_val("rdiv_start", Start, 1);
        for (int j = 1; j <= 6; j++) begin
            cyc(1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01);
            check_val("rdiv_stall", Stall, 1);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("midrst_stall", Stall, 0);
        check_val("midrst_stallcnt", StallCnt, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("postrst_stall", Stall, 0);
        cyc(1'b1, 4'b0001, 2'b00, 1'b0, 4'd0, 2'b01);
        check_val("postrst_start", Start, 1);
        check_val("postrst_time", Time, 5);
        for (int j = 1; j <= 5; j++) begin
            cyc(1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01);
            check_val("postrst_stall_win", Stall, 1);
        end
        cyc(1'b0, 4'd0, 2'b00, 1'b0, 4'd0, 2'b01);
        check_val("postrst_release", Stall, 0);
        check_val("postrst_stallcnt", StallCnt, 6);
        check_val("postrst_proto", ProtoErr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
